// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Used by dmem_load_store_unit and dmem_lane_align.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_W = 4;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables / data shift and load
// byte/half extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] lane_data,
  output logic [XLEN-1:0] load_data
);

  logic [1:0]      lane;
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic            sext;

  always_comb begin
    lane      = 2'b00;
    be        = '0;
    lane_data = '0;
    load_data = '0;
    sext      = ~funct3[2];
    // Low address bits the access size cannot use are forced to zero.
    case (funct3[1:0])
      2'b00:   lane = offset;
      2'b01:   lane = {offset[1], 1'b0};
      default: lane = 2'b00;
    endcase
    shamt   = {lane, 3'b000};
    shifted = load_word >> shamt;
    case (funct3)
      F3_B, F3_BU: begin
        be        = BE_W'(1) << lane;
        lane_data = XLEN'(store_data[7:0]) << shamt;
        load_data = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be        = BE_W'(3) << lane;
        lane_data = XLEN'(store_data[15:0]) << shamt;
        load_data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        be        = '1;
        lane_data = store_data;
        load_data = load_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_load_store_unit.sv
// Load/store unit: req/gnt/rvalid bus handshake, lane alignment, core stall.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module dmem_load_store_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReq,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  output logic            Stall,
  output logic [XLEN-1:0] RD,
  output logic            RDValid,
  output logic            MemErr,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;
  logic            timeout;
  logic            bad_req;
  logic [2:0]      la_f3;
  logic [1:0]      la_off;
  logic [BE_W-1:0] la_be;
  logic [XLEN-1:0] la_wdata;
  logic [XLEN-1:0] la_rdata;

  // One aligner serves both paths: live inputs while idle, captured request after.
  assign la_f3  = (state_q == S_IDLE) ? funct3 : f3_q;
  assign la_off = (state_q == S_IDLE) ? ALUResult[1:0] : off_q;

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3     (la_f3),
    .offset     (la_off),
    .store_data (WriteData),
    .load_word  (bus_rdata),
    .be         (la_be),
    .lane_data  (la_wdata),
    .load_data  (la_rdata)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad_req = !f3_supported(funct3) || misaligned(funct3, ALUResult[1:0]);
`else
  assign bad_req = !f3_supported(funct3);
`endif

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          Stall   = 1'b1;
          state_d = bad_req ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (bus_gnt)      state_d = we_q ? S_DONE : S_WAIT;
        else if (timeout) state_d = S_DONE;
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (bus_rvalid || timeout) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_req = (state_q == S_REQ);
  assign bus_we  = (state_q == S_REQ) && we_q;
  assign RDValid = (state_q == S_DONE) && !we_q && !err_q;
  assign MemErr  = (state_q == S_DONE) && err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      RD        <= '0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MemReq) begin
            we_q      <= MemWrite;
            f3_q      <= funct3;
            off_q     <= ALUResult[1:0];
            err_q     <= bad_req;
            cnt_q     <= '0;
            bus_addr  <= {ALUResult[XLEN-1:2], 2'b00};
            bus_be    <= la_be;
            bus_wdata <= la_wdata;
            if (bad_req) RD <= '0;
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            cnt_q <= '0;
          end else if (timeout) begin
            err_q <= 1'b1;
            RD    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            RD <= la_rdata;
          end else if (timeout) begin
            err_q <= 1'b1;
            RD    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_load_store_unit.md
Name: dmem_load_store_unit

Overview:
- Load/store unit that produces the `RD` (read data) word consumed by the ResultSrc writeback mux; it is the writer side of that mux's `RD` input.
- Takes core memory requests (address = `ALUResult`, store data = `WriteData`, size/sign = `funct3`).
- Runs a request/grant/response handshake to a data-memory bus, applies byte lanes and sign/zero extension, and stalls the core until done.

Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles allowed in `S_REQ` or `S_WAIT` before the access aborts with error.
- `XLEN`, default 32: data and address width.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `MemReq`  in  1  core requests an access this cycle; sampled only in `S_IDLE`
- `MemWrite`  in  1  1 = store, 0 = load
- `funct3`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores)
- `ALUResult`  in  XLEN  byte address
- `WriteData`  in  XLEN  store data, right-justified
- `Stall`  out  1  core must hold its inputs
- `RD`  out  XLEN  extended load data
- `RDValid`  out  1  one-cycle pulse; `RD` is valid
- `MemErr`  out  1  one-cycle pulse; access aborted
- `bus_req`  out  1  bus request
- `bus_we`  out  1  bus write enable
- `bus_addr`  out  XLEN  word-aligned address (bits [1:0] = 00)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  XLEN  lane-shifted store data
- `bus_gnt`  in  1  bus accepted the request this cycle
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  XLEN  read word

Behaviour:
- Reset (async, active-high): state = `S_IDLE`; `Stall`, `RDValid`, `MemErr`, `bus_req`, `bus_we` = 0; `RD`, `bus_addr`, `bus_be`, `bus_wdata` = 0; timeout counter = 0.
- FSM states: `S_IDLE`, `S_REQ`, `S_WAIT`, `S_DONE`.
- `S_IDLE`, `MemReq`=1:
  - Register address, `funct3`, `MemWrite` and lane-shifted data.
  - Go to `S_REQ`. `Stall` goes high combinationally in the same cycle.
- `S_REQ`:
  - `bus_req`=1; `bus_addr`, `bus_be`, `bus_wdata`, `bus_we` held stable until `bus_gnt`.
  - On `bus_gnt`: a store goes to `S_DONE`; a load goes to `S_WAIT`.
- `S_WAIT`:
  - `bus_req`=0.
  - On `bus_rvalid`: select the addressed byte/half from `bus_rdata`, sign- or zero-extend per `funct3`, register into `RD`, go to `S_DONE`.
- `S_DONE`: `Stall`=0 for one cycle; `RDValid`=1 for loads only; return to `S_IDLE`. A `MemReq` in this cycle is ignored; the core re-presents it.
- `Stall` = 1 whenever state ≠ `S_IDLE` and state ≠ `S_DONE`, or (`S_IDLE` and `MemReq`).
- Byte enables:
  - Byte: `be = 0001 << addr[1:0]`.
  - Half: `be = 0011 << {addr[1],0}`.
  - Word: `be = 1111`.
  - `wdata` is replicated/shifted to the same lane.
- Latency: minimum load 4 cycles (request → `RDValid`) with `gnt` and `rvalid` on first opportunity; minimum store 3 cycles.
- Timeout:
  - Counter clears on entry to `S_REQ` and `S_WAIT`, and increments each cycle spent there.
  - At `TIMEOUT_CYCLES` without `gnt`/`rvalid`: `MemErr` pulses, `RD` = 0, go to `S_DONE` with `RDValid`=0.
  - `gnt`/`rvalid` arriving in the same cycle as the timeout wins, and no error is raised.
- `bus_rvalid` outside `S_WAIT` is ignored. `bus_gnt` outside `S_REQ` is ignored.
- Unsupported `funct3` (011, 110, 111): no bus access; `MemErr` pulse through `S_DONE`.
- Reset mid-access: immediate return to `S_IDLE`; outstanding bus response discarded.

Optional Feature:
- Macro: `DMEM_MISALIGN_CHECK_EN`.
- Defined:
  - Half with `addr[0]`=1, or word with `addr[1:0]`≠00, never issues `bus_req`.
  - Goes `S_IDLE` → `S_DONE`: 2-cycle access with `Stall` high for 1 cycle, `MemErr` pulse, `RD` = 0.
- Undefined:
  - Ignored low bits are forced to zero: half uses `addr[1]` only, word uses lane 0.
  - Access proceeds normally with no error.

Decomposition:
- Package `dmem_pkg`:
  - State enum.
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Byte-enable widths.
- One sub-module: `dmem_lane_align` (combinational):
  - Store lane shift and byte-enable generation.
  - Load byte/half extraction with sign/zero extension.
  - Shared by both paths.

Test Plan:
- LW at `0x0000_0010`, `gnt` and `rvalid` immediate, `rdata`=`0xDEADBEEF` → `bus_be`=`1111`, `RD`=`0xDEADBEEF`, `RDValid` on 4th cycle, `Stall` high 3 cycles.
- LB at `0x13`, `rdata`=`0x80FF_0000` → `RD`=`0xFFFF_FF80`; LBU at the same address → `RD`=`0x0000_0080`; LH at `0x12` → `RD`=`0xFFFF_80FF`.
- SB at `0x21`, `WriteData`=`0x0000_00AB`:
  - `bus_be`=`0010`, `bus_wdata[15:8]`=`0xAB`, `bus_we`=1.
  - `gnt` delayed 3 cycles → `bus_req` and `bus_addr`=`0x20` held stable throughout, `RDValid` never asserted.
- LW with `gnt` never asserted, `TIMEOUT_CYCLES`=4 → `MemErr` pulse after 4 cycles in `S_REQ`, `RD`=0, `Stall` drops.
- `reset` asserted while in `S_WAIT`, then `rvalid` arrives 1 cycle later → all outputs 0, `RDValid` stays 0.
- With `DMEM_MISALIGN_CHECK_EN` defined: LW at `0x02` → no `bus_req`, `MemErr` pulse. Without the macro: same request → `bus_addr`=`0x00`, `be`=`1111`, normal completion.
